// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// No logic; types, funct3 codes and a size helper only.
// Not applicable.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    LD_FMT   = 3'd2,
    ST_MERGE = 3'd3,
    WR       = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size in bytes; illegal codes report a word so bounds stay conservative.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_bytes = 3'd1;
      F3_H, F3_HU: size_bytes = 3'd2;
      default:     size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Extracts the low byte/halfword of a memory word and sign or zero extends it.
// Purely combinational, zero latency.
// No flow control.
module lsu_load_format
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  // Size/sign selection; LW and anything unrecognised pass the word through.
  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{rdata[7]}}, rdata[7:0]};
      F3_H:    data = {{16{rdata[15]}}, rdata[15:0]};
      F3_BU:   data = {24'd0, rdata[7:0]};
      F3_HU:   data = {16'd0, rdata[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: one request at a time, byte/half stores by read-modify-write.
// Latency accept->resp: error 1, SW 2, load 3, SB/SH 4 cycles.
// req_ready only in IDLE; LSU_MISALIGN_CHECK_EN adds alignment errors.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wr_en,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state, state_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [2:0]        lat_funct3;
  logic              lat_write;

  logic              accept;
  logic              f3_legal;
  logic              out_of_range;
  logic              misaligned;
  logic              req_err;
  logic [ADDR_W:0]   req_end;
  logic [31:0]       fmt_data;

  assign accept = req_valid && req_ready;

  // Legal funct3 set depends on direction: stores have no unsigned forms.
  always_comb begin
    f3_legal = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !req_write;
      default:          f3_legal = 1'b0;
    endcase
  end

  // One extra bit so a request near the top of the address space cannot wrap.
  assign req_end      = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, size_bytes(req_funct3)};
  assign out_of_range = req_end > (ADDR_W+1)'(MEM_BYTES);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
                      ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
  // The memory accepts any byte address, so unaligned accesses just proceed.
  assign misaligned = 1'b0;
`endif

  assign req_err = !f3_legal || out_of_range || misaligned;

  // Write strobe is gated by reset so a reset landing in WR kills the negedge write.
  assign mem_wr_en = (state == WR) && !reset;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  lsu_load_format u_fmt (
    .funct3 (lat_funct3),
    .rdata  (mem_rdata),
    .data   (fmt_data)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake; errored requests never leave IDLE.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !req_err) begin
          if (req_write && (req_funct3 == F3_W)) state_nxt = WR;
          else                                   state_nxt = RD;
        end
      end
      RD:       state_nxt = lat_write ? ST_MERGE : LD_FMT;
      LD_FMT:   state_nxt = IDLE;
      ST_MERGE: state_nxt = WR;
      WR:       state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Request latch; ST_MERGE reuses the write-data register for the merged word.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
      lat_write  <= 1'b0;
    end else if (accept) begin
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
      lat_funct3 <= req_funct3;
      lat_write  <= req_write;
    end else if (state == ST_MERGE) begin
      if (lat_funct3 == F3_B) lat_wdata <= {mem_rdata[31:8], lat_wdata[7:0]};
      else                    lat_wdata <= {mem_rdata[31:16], lat_wdata[15:0]};
    end
  end

  // Response pulse; rdata only changes when a response is issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      if (accept && req_err) begin
        resp_valid <= 1'b1;
        resp_error <= 1'b1;
        resp_rdata <= '0;
      end else if (state == LD_FMT) begin
        resp_valid <= 1'b1;
        resp_rdata <= fmt_data;
      end else if (state == WR) begin
        resp_valid <= 1'b1;
        resp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl with a byte-array memory and reference model.
// Honours LSU_MISALIGN_CHECK_EN when deciding expected errors.
// Requests are issued one at a time, next one right after each response.
module tb_lsu_mem_ctrl;

  localparam int MEM_BYTES = 1024;
  localparam int ADDR_W    = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid, resp_error;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_wr_en;

  lsu_mem_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Memory seen by the DUT: word starting at any byte address, little-endian.
  logic [7:0] mem     [0:MEM_BYTES+3];
  logic [7:0] ref_mem [0:MEM_BYTES+3];
  int wr_cnt = 0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (a < MEM_BYTES + 4) return mem[a];
    return 8'h00;
  endfunction

  always @(posedge clock)
    mem_rdata <= {mem_byte(mem_addr + 3), mem_byte(mem_addr + 2),
                  mem_byte(mem_addr + 1), mem_byte(mem_addr)};

  always @(negedge clock) begin
    if (mem_wr_en) begin
      wr_cnt++;
      for (int i = 0; i < 4; i++)
        if (mem_addr + i < MEM_BYTES + 4) mem[mem_addr + i] = mem_wdata[8*i +: 8];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: byte-level behaviour of each request, independent of the FSM.
  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output exp_t e);
    logic legal, mis;
    int   sz;
    logic [31:0] w;
    legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis   = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    if (sz == 2 && addr[0]) mis = 1'b1;
    if (sz == 4 && addr[1:0] != 2'b00) mis = 1'b1;
`endif
    e.rdata = 32'h0; e.err = 1'b0; e.lat = 1; e.writes = 0;
    if (!legal || (longint'(addr) + sz > MEM_BYTES) || mis) begin
      e.err = 1'b1;
    end else if (wr) begin
      for (int i = 0; i < sz; i++) ref_mem[addr + i] = wd[8*i +: 8];
      e.lat = (sz == 4) ? 2 : 4;
      e.writes = 1;
    end else begin
      w = {ref_mem[addr+3], ref_mem[addr+2], ref_mem[addr+1], ref_mem[addr]};
      case (f3)
        3'd0: e.rdata = {{24{w[7]}}, w[7:0]};
        3'd1: e.rdata = {{16{w[15]}}, w[15:0]};
        3'd4: e.rdata = {24'h0, w[7:0]};
        3'd5: e.rdata = {16'h0, w[15:0]};
        default: e.rdata = w;
      endcase
      e.lat = 3;
    end
  endtask

  // Entered and left at #1 after a posedge; issues one request and scores its response.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    exp_t e;
    int   lat, wr0;
    model(wr, f3, addr, wd, e);
    exp_q.push_back(e);
    check_val("req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    wr0 = wr_cnt;
    @(posedge clock); #1;
    req_valid = 1'b0; req_write = ~wr; req_funct3 = 3'b111; req_addr = '1; req_wdata = '1;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clock); #1;
      lat++;
    end
    e = exp_q.pop_front();
    check_val("resp_valid", {31'b0, resp_valid}, 32'd1);
    check_val("latency", lat, e.lat);
    check_val("resp_error", {31'b0, resp_error}, {31'b0, e.err});
    check_val("resp_rdata", resp_rdata, e.rdata);
    check_val("mem_writes", wr_cnt - wr0, e.writes);
    check_val("mem_addr", mem_addr, addr);
  endtask

  initial begin
    int wr0;
    for (int i = 0; i < MEM_BYTES + 4; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check_val("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_val("rst_resp_error", {31'b0, resp_error}, 32'd0);
    check_val("rst_resp_rdata", resp_rdata, 32'd0);
    check_val("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Word store/load and sub-word loads of the same word.
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 3'd2, 32'h10, 32'h0);
    do_req(1'b0, 3'd0, 32'h13, 32'h0);
    do_req(1'b0, 3'd4, 32'h13, 32'h0);
    do_req(1'b0, 3'd1, 32'h12, 32'h0);
    do_req(1'b0, 3'd5, 32'h12, 32'h0);
    // Byte RMW into byte 0x11, then reread the word at 0x10.
    do_req(1'b1, 3'd0, 32'h11, 32'h12345655);
    do_req(1'b0, 3'd2, 32'h10, 32'h0);
    // Halfword at an odd address: error only with the alignment check.
    do_req(1'b0, 3'd1, 32'h11, 32'h0);
    // Halfword store and its sign/zero views.
    do_req(1'b1, 3'd1, 32'h30, 32'hAAAA8001);
    do_req(1'b0, 3'd2, 32'h30, 32'h0);
    do_req(1'b0, 3'd1, 32'h30, 32'h0);
    do_req(1'b0, 3'd5, 32'h30, 32'h0);
    // Error paths and the exact upper bound.
    do_req(1'b0, 3'd3, 32'h10, 32'h0);
    do_req(1'b0, 3'd2, 32'd1021, 32'h0);
    do_req(1'b1, 3'd4, 32'h10, 32'h11223344);
    do_req(1'b1, 3'd2, 32'd1021, 32'h55667788);
    do_req(1'b0, 3'd0, 32'd1023, 32'h0);
    do_req(1'b0, 3'd2, 32'd1020, 32'h0);

    // Random mix near the low addresses and the top boundary.
    for (int k = 0; k < 40; k++)
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 40)) + (($urandom_range(0, 3) == 0) ? 32'd990 : 32'd0),
             $urandom);

    // Reset during the WR cycle of an SB must suppress the write.
    do_req(1'b1, 3'd2, 32'h20, 32'hCAFEF00D);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h20;
    req_wdata = 32'h00000077;
    wr0 = wr_cnt;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_val("wr_en_in_wr", {31'b0, mem_wr_en}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("wr_en_gated", {31'b0, mem_wr_en}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    check_val("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_val("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check_val("mid_rst_writes", wr_cnt - wr0, 32'd0);
    @(posedge clock); #1;
    do_req(1'b0, 3'd2, 32'h20, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
